// File: rtl/inst_mem_stream_loader_pkg.sv
// Shared types and elaboration helpers for the streaming instruction-memory loader.
package inst_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } loader_state_e;

    localparam int unsigned NOP_WORD_DEFAULT = 0;

    function automatic int unsigned chunks_of(input int unsigned word_w, input int unsigned in_w);
        return word_w / in_w;
    endfunction

    function automatic bit chunks_fit(input int unsigned word_w, input int unsigned in_w);
        return (in_w != 0) && (word_w >= in_w) && ((word_w % in_w) == 0);
    endfunction

endpackage

// File: rtl/inst_mem_stream_loader_word_assembler.sv
// Packs IN_W-bit stream chunks MSB-first into WORD_W-bit words; a last chunk
// flushes a partial word with zero low bits.
module word_assembler
    import inst_mem_pkg::*;
#(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned IN_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              chunk_valid_i,
    input  logic [IN_W-1:0]   chunk_i,
    input  logic              last_i,
    output logic              word_valid_c_o,
    output logic [WORD_W-1:0] word_c_o
);

    localparam int unsigned CHUNKS = chunks_of(WORD_W, IN_W);
    localparam int unsigned CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHUNKS - 1);

    logic [WORD_W-1:0] acc_q;
    logic [WORD_W-1:0] placed_c;
    logic [CNT_W-1:0]  cnt_q;

    // Drop the incoming chunk into the slot selected by the chunk counter.
    always_comb begin
        placed_c = '0;
        for (int unsigned k = 0; k < CHUNKS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                placed_c[WORD_W-1-k*IN_W -: IN_W] = chunk_i;
            end
        end
    end

    assign word_c_o       = acc_q | placed_c;
    assign word_valid_c_o = chunk_valid_i && (last_i || (cnt_q == CNT_LAST));

    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (chunk_valid_i) begin
            if (word_valid_c_o) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else begin
                acc_q <= word_c_o;
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/inst_mem_stream_loader.sv
// Streams a program into the instruction RAM and serves registered IF fetches.
// Define LOADER_CHECKSUM_EN to treat the final word as an XOR checksum trailer.
module inst_mem_stream_loader
    import inst_mem_pkg::*;
#(
    parameter int unsigned       WORD_W   = 16,
    parameter int unsigned       IN_W     = 8,
    parameter int unsigned       ADDR_W   = 20,
    parameter logic [WORD_W-1:0] NOP_WORD = WORD_W'(NOP_WORD_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [WORD_W-1:0] fetch_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow,
    output logic              chk_err
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    if (!chunks_fit(WORD_W, IN_W)) begin : g_bad_chunking
        $error("inst_mem_stream_loader: WORD_W must be an integer multiple of IN_W");
    end

    loader_state_e     state_q;
    logic              in_ready_q;
    logic              busy_q;
    logic              done_q;
    logic              ovf_q;
    logic [CNT_W-1:0]  ptr_q;
    logic [WORD_W-1:0] fetch_q;
    logic [WORD_W-1:0] mem [DEPTH];

    logic              fire_c;
    logic              start_c;
    logic              full_c;
    logic              is_trailer_c;
    logic              wr_en_c;
    logic              word_valid_c;
    logic [WORD_W-1:0] word_c;

    assign fire_c  = rst_n && in_valid && in_ready_q;
    assign start_c = load_start && (state_q != ST_LOAD);
    // The pointer saturates at DEPTH, so its MSB alone marks a full RAM.
    assign full_c  = ptr_q[ADDR_W];
    assign wr_en_c = word_valid_c && !is_trailer_c && !full_c;

    word_assembler #(
        .WORD_W (WORD_W),
        .IN_W   (IN_W)
    ) u_asm (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear_i        (start_c),
        .chunk_valid_i  (fire_c),
        .chunk_i        (in_data),
        .last_i         (in_last),
        .word_valid_c_o (word_valid_c),
        .word_c_o       (word_c)
    );

`ifdef LOADER_CHECKSUM_EN
    logic              chk_q;
    logic [WORD_W-1:0] xor_q;

    // Running XOR of stored words, compared against the trailer at completion.
    always_ff @(posedge clk) begin
        if (!rst_n || start_c) begin
            chk_q <= 1'b0;
            xor_q <= '0;
        end else begin
            if (wr_en_c) begin
                xor_q <= xor_q ^ word_c;
            end
            if (fire_c && in_last) begin
                chk_q <= (xor_q != word_c);
            end
        end
    end

    assign is_trailer_c = in_last;
    assign chk_err      = chk_q;
`else
    assign is_trailer_c = 1'b0;
    assign chk_err      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            ptr_q      <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_c) begin
                        state_q    <= ST_LOAD;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        ovf_q      <= 1'b0;
                        ptr_q      <= '0;
                    end
                end
                ST_LOAD: begin
                    if (wr_en_c) begin
                        ptr_q <= ptr_q + CNT_W'(1);
                    end
                    if (word_valid_c && !is_trailer_c && full_c) begin
                        ovf_q <= 1'b1;
                    end
                    if (fire_c && in_last) begin
                        state_q    <= ST_DONE;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[ptr_q[ADDR_W-1:0]] <= word_c;
        end
    end

    // Fetch port returns NOP while a load owns the RAM.
    always_ff @(posedge clk) begin
        if (!rst_n || busy_q) begin
            fetch_q <= NOP_WORD;
        end else if (fetch_en) begin
            fetch_q <= mem[fetch_addr];
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = ovf_q;
    assign word_count = ptr_q;
    assign fetch_data = fetch_q;

endmodule

// File: tb/tb_inst_mem_stream_loader.sv
// Scoreboard bench for inst_mem_stream_loader (small RAM to reach overflow).
module tb_inst_mem_stream_loader;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned IN_W   = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned CH     = WORD_W / IN_W;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam logic [WORD_W-1:0] NOP = '0;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    typedef struct {
        int wc;
        bit ovf;
        bit chk;
    } load_exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_start = 1'b0;
    logic              in_valid = 1'b0;
    logic [IN_W-1:0]   in_data = '0;
    logic              in_last = 1'b0;
    logic              fetch_en = 1'b0;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic              in_ready, busy, done, overflow, chk_err;
    logic [WORD_W-1:0] fetch_data;
    logic [ADDR_W:0]   word_count;

    inst_mem_stream_loader #(
        .WORD_W (WORD_W),
        .IN_W   (IN_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .fetch_en   (fetch_en),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .busy       (busy),
        .done       (done),
        .word_count (word_count),
        .overflow   (overflow),
        .chk_err    (chk_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference state: program image and expected responses.
    logic [IN_W-1:0]   stim_q[$];
    logic [WORD_W-1:0] ref_mem [DEPTH];
    bit                ref_ok  [DEPTH];
    logic [WORD_W-1:0] fq[$];
    load_exp_t         lq[$];

    function automatic void model(input int n_used, input bit complete, output load_exp_t le);
        int nw, ndata, nwr;
        logic [WORD_W-1:0] w, x, trailer;
        nw      = complete ? (n_used + CH - 1) / CH : n_used / CH;
        ndata   = (CS && complete) ? nw - 1 : nw;
        nwr     = (ndata > DEPTH) ? DEPTH : ndata;
        x       = '0;
        trailer = '0;
        for (int i = 0; i < nw; i++) begin
            w = '0;
            for (int c = 0; c < CH; c++) begin
                if (i * CH + c < n_used) begin
                    w = w | (WORD_W'(stim_q[i*CH+c]) << (WORD_W - (c + 1) * IN_W));
                end
            end
            if (i < nwr) begin
                ref_mem[i] = w;
                ref_ok[i]  = 1'b1;
                x          = x ^ w;
            end
            if (i == nw - 1) trailer = w;
        end
        le.wc  = nwr;
        le.ovf = (ndata > DEPTH);
        le.chk = CS && complete && (x != trailer);
    endfunction

    // Monitor: every cycle fetch_data is checked; a rising done pops a load record.
    bit                arm_p = 1'b0, busy_p = 1'b0, rst_p = 1'b0, done_p = 1'b0;
    logic [WORD_W-1:0] last_exp = '0;
    logic [WORD_W-1:0] mon_e;
    load_exp_t         mon_le;

    always @(negedge clk) begin
        if (!rst_p) begin
            check("fetch_after_reset", 32'(fetch_data), 32'(NOP));
            last_exp = NOP;
        end else if (arm_p) begin
            if (fq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL fetch_unexpected: got %h want no read", fetch_data);
            end else begin
                mon_e = fq.pop_front();
                check("fetch_data", 32'(fetch_data), 32'(mon_e));
                last_exp = mon_e;
            end
        end else if (busy_p) begin
            check("fetch_nop_while_busy", 32'(fetch_data), 32'(NOP));
            last_exp = NOP;
        end else begin
            check("fetch_hold", 32'(fetch_data), 32'(last_exp));
        end

        if (done && !done_p) begin
            if (lq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done_unexpected: got done=1 want no completion");
            end else begin
                mon_le = lq.pop_front();
                check("word_count", 32'(word_count), 32'(mon_le.wc));
                check("overflow", 32'(overflow), 32'(mon_le.ovf));
                check("chk_err", 32'(chk_err), 32'(mon_le.chk));
                check("busy_at_done", 32'(busy), 32'(0));
                check("in_ready_at_done", 32'(in_ready), 32'(0));
            end
        end
        arm_p  = fetch_en;
        busy_p = busy;
        rst_p  = rst_n;
        done_p = done;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_fetch(input int a);
        if (ref_ok[a]) begin
            fetch_en   = 1'b1;
            fetch_addr = ADDR_W'(a);
            fq.push_back(ref_mem[a]);
            tick(1);
            fetch_en = 1'b0;
        end
    endtask

    // Streams stim_q; abort_at >= 0 stops after that many accepted chunks.
    task automatic run_load(input bit poke, input bit fetch_in, input int abort_at);
        int   n;
        int   idx;
        int   guard;
        logic rdy;
        n     = stim_q.size();
        idx   = 0;
        guard = 0;
        load_start = 1'b1;
        tick(1);
        load_start = 1'b0;
        if (fetch_in) begin
            fetch_en   = 1'b1;
            fetch_addr = '0;
            fq.push_back(NOP);
        end
        while (idx < n && guard < 2000) begin
            if (abort_at >= 0 && idx == abort_at) break;
            in_valid   = ($urandom_range(0, 3) != 0);
            in_data    = stim_q[idx];
            in_last    = (idx == n - 1);
            load_start = poke && (idx == 1);
            @(negedge clk);
            rdy = in_ready;
            tick(1);
            fetch_en   = 1'b0;
            load_start = 1'b0;
            if (in_valid && rdy) idx++;
            guard++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (guard >= 2000) begin
            total++;
            bad++;
            $display("FAIL stream_timeout: got %0d chunks accepted want %0d", idx, n);
        end
    endtask

    task automatic full_load(input bit poke, input bit fetch_in);
        load_exp_t le;
        model(stim_q.size(), 1'b1, le);
        lq.push_back(le);
        run_load(poke, fetch_in, -1);
        tick(3);
    endtask

    initial begin
        load_exp_t le;
        int        n;

        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_overflow", 32'(overflow), 32'(0));
        check("rst_chk_err", 32'(chk_err), 32'(0));
        check("rst_word_count", 32'(word_count), 32'(0));

        // Two full words.
        stim_q = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        full_load(1'b0, 1'b0);
        check("done_sticky", 32'(done), 32'(1));
        do_fetch(1);
        do_fetch(0);
        tick(2);

        // Odd chunk count pads the final word.
        stim_q = '{8'h12, 8'h34, 8'h56};
        full_load(1'b0, 1'b1);
        do_fetch(1);
        do_fetch(0);

        // Checksum-shaped programs: matching and mismatching trailer.
        stim_q = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'hB9, 8'hF9};
        full_load(1'b1, 1'b0);
        do_fetch(2);
        stim_q = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00};
        full_load(1'b0, 1'b0);
        do_fetch(1);

        // Program larger than the RAM.
        stim_q.delete();
        for (int i = 0; i < 36; i++) stim_q.push_back(IN_W'($urandom));
        full_load(1'b1, 1'b1);
        for (int a = 0; a < DEPTH; a += 5) do_fetch(a);

        // Reset after one word plus a partial chunk; word 0 must survive.
        stim_q = '{8'h5A, 8'hC3, 8'h77, 8'h88, 8'h99, 8'hAA};
        model(3, 1'b0, le);
        run_load(1'b0, 1'b0, 3);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_in_ready", 32'(in_ready), 32'(0));
        check("abort_word_count", 32'(word_count), 32'(0));
        tick(1);
        do_fetch(0);
        stim_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        full_load(1'b0, 1'b0);
        do_fetch(0);
        do_fetch(1);

        // Randomized programs and fetches.
        for (int t = 0; t < 12; t++) begin
            n = $urandom_range(1, 40);
            stim_q.delete();
            for (int i = 0; i < n; i++) stim_q.push_back(IN_W'($urandom));
            full_load(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int f = 0; f < 4; f++) do_fetch($urandom_range(0, DEPTH - 1));
            tick($urandom_range(0, 2));
        end

        tick(5);
        check("loads_drained", 32'(lq.size()), 32'(0));
        check("fetches_drained", 32'(fq.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
